// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding, default widths and reset constants for the counter sequencer
package counter_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   localparam int DEF_N = 4;
   localparam int DEF_PRESCALE_W = 4;
   localparam logic LIMIT_RST_BIT = 1'b1;
endpackage

// File: rtl/counter_core.sv
// counter_core: N-bit up-counter register with synchronous clear (priority) and enable
module counter_core
   import counter_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         clr,
   input  logic         en,
   output logic [N-1:0] q
);
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= q + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: configures and sequences a prescaled up-counter in one-shot or periodic mode,
// pulsing Done once per terminal-count event.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Cfg_Valid,
   output logic                  Cfg_Ready,
   input  logic [N-1:0]          Cfg_Limit,
   input  logic [PRESCALE_W-1:0] Cfg_Prescale,
   input  logic                  Cfg_Periodic,
   input  logic                  Start,
   input  logic                  Stop,
   input  logic                  Hold,
   output logic [N-1:0]          Count,
   output logic                  Busy,
   output logic                  Done
);
   state_t                state, state_nx;
   logic [N-1:0]          lim;
   logic [PRESCALE_W-1:0] pre, psc;
   logic                  periodic, run, go, step, term;
   assign run  = state == RUN;
   assign go   = !run && Start;
   assign step = run && !Hold && psc == pre;
   assign term = step && Count == lim;
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = run ? ((Stop || (term && !periodic)) ? IDLE : RUN) : (Start ? RUN : IDLE);
   always_comb begin
      Busy      = run;
      Cfg_Ready = !run;
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         lim      <= {N{LIMIT_RST_BIT}};
         pre      <= '0;
         periodic <= 1'b0;
      end else if (Cfg_Valid && Cfg_Ready) begin
         lim      <= Cfg_Limit;
         pre      <= Cfg_Prescale;
         periodic <= Cfg_Periodic;
      end
   // Stop wins over a coinciding terminal event: no Done, no wrap
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         psc  <= '0;
         Done <= 1'b0;
      end else begin
         psc  <= (go || step) ? '0 : (run && !Hold) ? psc + 1'b1 : psc;
         Done <= term && !Stop;
      end
   counter_core #(.N(N)) u_core (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (go || (term && !Stop)),
      .en    (step && !Stop),
      .q     (Count)
   );
endmodule
